// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and helpers for the RAM port arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_LOAD   = 2'd2,
    ST_STORE  = 2'd3
  } state_t;

  typedef enum logic {
    GNT_ICACHE = 1'b0,
    GNT_LSB    = 1'b1
  } grant_t;

  localparam logic [1:0]  SIZE_BYTE = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;
  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // The reserved encoding 2'b11 falls through to a full word.
  function automatic logic [6:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 7'd1;
      SIZE_HALF: return 7'd2;
      SIZE_WORD: return 7'd4;
      default:   return 7'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-wide RAM port arbiter for icache refills and LSB accesses
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          LINE_BYTES = 16,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    icache_req,
  input  logic [31:0]             icache_addr,
  output logic                    icache_done,
  output logic [LINE_BYTES*8-1:0] icache_line,
  input  logic                    lsb_req,
  input  logic                    lsb_wr,
  input  logic [31:0]             lsb_addr,
  input  logic [1:0]              lsb_size,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  input  logic                    rob_clear,
  input  logic                    io_buffer_full,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr
);

  localparam int CW = $clog2(LINE_BYTES) + 1;
  localparam int LW = LINE_BYTES * 8;

  state_t          state_q, state_d;
  grant_t          last_grant_q, last_grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   len_q, len_d;
  logic [31:0]     base_q, base_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            mem_wr_q, mem_wr_d;
  logic [31:0]     mem_a_d;
  logic [7:0]      mem_dout_d;
  logic            icache_done_d, lsb_done_d;
  logic [LW-1:0]   icache_line_d;
  logic [31:0]     lsb_rdata_d;

  logic            ic_elig, lsb_elig, lsb_io_blocked;
  logic            grant_ic, grant_lsb;
  logic            read_last, store_last;
  logic [31:0]     cur_addr;

  // A requester whose done pulse is showing this cycle must not be re-granted.
  assign lsb_io_blocked = lsb_wr && (lsb_addr >= IO_BASE) && io_buffer_full;
  assign ic_elig        = icache_req && !icache_done;
  assign lsb_elig       = lsb_req && !lsb_done && !lsb_io_blocked;
  assign read_last      = (cnt_q == len_q + CW'(1));
  assign store_last     = (cnt_q == len_q);
  assign cur_addr       = base_q + {{(32-CW){1'b0}}, cnt_q};

  // Frozen cycles must never repeat a RAM write.
  assign mem_wr = mem_wr_q & rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_ICACHE;
      cnt_q        <= '0;
      len_q        <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      mem_wr_q     <= 1'b0;
      mem_a        <= '0;
      mem_dout     <= '0;
      icache_done  <= 1'b0;
      lsb_done     <= 1'b0;
      icache_line  <= '0;
      lsb_rdata    <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      mem_wr_q     <= mem_wr_d;
      mem_a        <= mem_a_d;
      mem_dout     <= mem_dout_d;
      icache_done  <= icache_done_d;
      lsb_done     <= lsb_done_d;
      icache_line  <= icache_line_d;
      lsb_rdata    <= lsb_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_ic     = 1'b0;
    grant_lsb    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rob_clear) begin
          if (ic_elig && (!lsb_elig || last_grant_q == GNT_LSB)) begin
            grant_ic     = 1'b1;
            state_d      = ST_IFETCH;
            last_grant_d = GNT_ICACHE;
          end else if (lsb_elig) begin
            grant_lsb    = 1'b1;
            state_d      = lsb_wr ? ST_STORE : ST_LOAD;
            last_grant_d = GNT_LSB;
          end
        end
      end
      ST_IFETCH, ST_LOAD: begin
        if (rob_clear || read_last) state_d = ST_IDLE;
      end
      ST_STORE: begin
        if (store_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // cnt_q numbers the edge about to happen relative to the accepting edge E0;
  // reads capture byte k at edge k+2 because the RAM returns data one cycle late.
  always_comb begin
    cnt_d         = cnt_q;
    len_d         = len_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    mem_wr_d      = 1'b0;
    mem_a_d       = mem_a;
    mem_dout_d    = mem_dout;
    icache_done_d = 1'b0;
    lsb_done_d    = 1'b0;
    icache_line_d = icache_line;
    lsb_rdata_d   = lsb_rdata;
    case (state_q)
      ST_IDLE: begin
        if (grant_ic) begin
          base_d        = icache_addr;
          len_d         = CW'(LINE_BYTES);
          cnt_d         = CW'(1);
          mem_a_d       = icache_addr;
          icache_line_d = '0;
        end else if (grant_lsb) begin
          base_d  = lsb_addr;
          len_d   = CW'(size_bytes(lsb_size));
          wdata_d = lsb_wdata;
          cnt_d   = CW'(1);
          mem_a_d = lsb_addr;
          if (lsb_wr) begin
            mem_dout_d = lsb_wdata[7:0];
            mem_wr_d   = 1'b1;
          end else begin
            lsb_rdata_d = '0;
          end
        end
      end
      ST_IFETCH, ST_LOAD: begin
        if (rob_clear) begin
          cnt_d   = '0;
          mem_a_d = '0;
        end else begin
          if (cnt_q < len_q) mem_a_d = cur_addr;
          if (state_q == ST_IFETCH) begin
            for (int b = 0; b < LINE_BYTES; b++)
              if (cnt_q == CW'(b + 2)) icache_line_d[b*8 +: 8] = mem_din;
          end else begin
            for (int b = 0; b < 4; b++)
              if (cnt_q == CW'(b + 2)) lsb_rdata_d[b*8 +: 8] = mem_din;
          end
          if (read_last) begin
            cnt_d = '0;
            if (state_q == ST_IFETCH) icache_done_d = 1'b1;
            else                      lsb_done_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_STORE: begin
        if (store_last) begin
          cnt_d      = '0;
          mem_a_d    = '0;
          lsb_done_d = 1'b1;
        end else begin
          mem_a_d  = cur_addr;
          mem_wr_d = 1'b1;
          cnt_d    = cnt_q + CW'(1);
          for (int b = 0; b < 4; b++)
            if (cnt_q == CW'(b)) mem_dout_d = wdata_q[b*8 +: 8];
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst, rdy;
  logic         icache_req, icache_done;
  logic [31:0]  icache_addr;
  logic [127:0] icache_line;
  logic         lsb_req, lsb_wr, lsb_done;
  logic [31:0]  lsb_addr, lsb_wdata, lsb_rdata;
  logic [1:0]   lsb_size;
  logic         rob_clear, io_buffer_full;
  logic [7:0]   mem_din = 8'h00;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;

  int total = 0;
  int bad   = 0;
  int nwr   = 0;
  int ndone = 0;
  logic [7:0] wmem [0:4095];

  mem_arbiter #(.LINE_BYTES(16), .IO_BASE(32'h30000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_done(icache_done), .icache_line(icache_line),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr),
    .lsb_size(lsb_size), .lsb_wdata(lsb_wdata),
    .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .rob_clear(rob_clear), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [31:0] a);
    if (a >= 32'h100 && a <= 32'h103) return 8'(32'h11 * (a - 32'hFF));
    if (a[31:4] == 28'h20) return 8'(32'hA0 + {28'h0, a[3:0]});
    return 8'h00;
  endfunction

  // RAM model: one-cycle read latency, frozen together with the arbiter.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= rom(mem_a);
      if (mem_wr) begin
        wmem[mem_a[11:0]] <= mem_dout;
        nwr <= nwr + 1;
      end
    end
  end

  always @(posedge clk) if (icache_done) ndone <= ndone + 1;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [127:0] exp_line;
    int snap, errs;

    for (int i = 0; i < 16; i++) exp_line[i*8 +: 8] = 8'(32'hA0 + i);
    rst = 1'b0; rdy = 1'b1;
    icache_req = 1'b0; icache_addr = '0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_size = 2'b00; lsb_wdata = '0;
    rob_clear = 1'b0; io_buffer_full = 1'b0;
    tick(); tick();
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_dout", mem_dout, 0);
    chk("rst_dones", {icache_done, lsb_done}, 0);
    chk("rst_line", icache_line, 0);
    chk("rst_rdata", lsb_rdata, 0);
    rst = 1'b1;
    tick();

    // Word load at 0x100.
    snap = nwr;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_size = 2'b10;
    tick();
    chk("load_e0_addr", mem_a, 32'h100);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("load_no_early_done", lsb_done, 0);
    end
    chk("load_addr_hold", mem_a, 32'h103);
    tick();
    chk("load_done_e5", lsb_done, 1);
    chk("load_rdata", lsb_rdata, 32'h44332211);
    chk("load_no_write", nwr - snap, 0);
    lsb_req = 1'b0;
    tick();
    chk("load_done_pulse", lsb_done, 0);

    // Full-line refill at 0x200.
    icache_req = 1'b1; icache_addr = 32'h200;
    tick();
    chk("ifetch_e0_addr", mem_a, 32'h200);
    errs = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (mem_a !== 32'h200 + (k > 15 ? 15 : k)) errs++;
      if (icache_done !== 1'b0) errs++;
    end
    chk("ifetch_addr_seq", errs, 0);
    tick();
    chk("ifetch_done_e17", icache_done, 1);
    chk("ifetch_line", icache_line, exp_line);
    icache_req = 1'b0;
    tick();

    // Simultaneous requests right after reset: LSB first, icache in the done cycle.
    rst = 1'b0; tick(); rst = 1'b1;
    icache_req = 1'b1; icache_addr = 32'h200;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_size = 2'b00;
    tick();
    chk("both_lsb_first", mem_a, 32'h100);
    tick(); tick();
    chk("both_lsb_done", lsb_done, 1);
    chk("both_lsb_rdata", lsb_rdata, 32'h11);
    lsb_addr = 32'h102;
    tick();
    chk("both_icache_next", mem_a, 32'h200);
    for (int k = 1; k <= 17; k++) tick();
    chk("both_icache_done", icache_done, 1);
    chk("both_lsb_waited", mem_a, 32'h20F);
    icache_req = 1'b0;
    tick();
    chk("both_lsb_second", mem_a, 32'h102);
    tick(); tick();
    chk("both_lsb2_rdata", {lsb_done, lsb_rdata}, {1'b1, 32'h33});
    lsb_req = 1'b0;
    tick();

    // I/O store held off by io_buffer_full.
    snap = nwr;
    io_buffer_full = 1'b1;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30004; lsb_size = 2'b10; lsb_wdata = 32'hAABBCCDD;
    for (int k = 0; k < 5; k++) tick();
    chk("io_blocked_no_wr", nwr - snap, 0);
    chk("io_blocked_addr", mem_a, 32'h102);
    io_buffer_full = 1'b0;
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30004 + k, 8'(lsb_wdata >> (8 * k))}) errs++;
    end
    chk("io_store_seq", errs, 0);
    tick();
    chk("io_store_end", {lsb_done, mem_wr, mem_a}, {1'b1, 1'b0, 32'h0});
    chk("io_store_ram", {wmem[7], wmem[6], wmem[5], wmem[4]}, 32'hAABBCCDD);
    lsb_req = 1'b0;
    tick();

    // Flush during a refill, then a store that must survive a flush.
    icache_req = 1'b1; icache_addr = 32'h200;
    tick(); tick(); tick();
    rob_clear = 1'b1; icache_req = 1'b0;
    tick();
    chk("flush_ifetch_a", {icache_done, mem_a}, 0);
    rob_clear = 1'b0;
    snap = ndone;
    for (int k = 0; k < 20; k++) tick();
    chk("flush_no_done", ndone - snap, 0);
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h40; lsb_size = 2'b10; lsb_wdata = 32'h12345678;
    tick(); tick();
    rob_clear = 1'b1; lsb_req = 1'b0;
    tick();
    rob_clear = 1'b0;
    tick(); tick();
    chk("flush_store_done", lsb_done, 1);
    chk("flush_store_ram", {wmem[12'h43], wmem[12'h42], wmem[12'h41], wmem[12'h40]}, 32'h12345678);
    tick();

    // Three frozen cycles in the middle of a load.
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_size = 2'b10;
    tick(); tick(); tick();
    rdy = 1'b0;
    tick(); tick(); tick();
    chk("freeze_hold", {lsb_done, mem_a}, {1'b0, 32'h102});
    rdy = 1'b1;
    tick(); tick();
    chk("freeze_no_early", lsb_done, 0);
    tick();
    chk("freeze_result", {lsb_done, lsb_rdata}, {1'b1, 32'h44332211});
    lsb_req = 1'b0;
    tick();

    // Freeze and then reset in the middle of a store.
    snap = nwr;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h50; lsb_size = 2'b10; lsb_wdata = 32'hCAFEF00D;
    tick();
    chk("store_wr_on", mem_wr, 1);
    rdy = 1'b0;
    #1;
    chk("freeze_wr_gated", mem_wr, 0);
    tick();
    chk("freeze_store_hold", {mem_wr, mem_a}, {1'b0, 32'h50});
    rdy = 1'b1;
    tick();
    chk("store_byte1", {mem_a, mem_dout}, {32'h51, 8'hF0});
    rst = 1'b0; lsb_req = 1'b0;
    #1;
    chk("rst_async_outs", {mem_a, mem_wr, mem_dout, lsb_done, icache_done, lsb_rdata}, 0);
    chk("rst_async_line", icache_line, 0);
    tick();
    rst = 1'b1;
    chk("rst_store_writes", nwr - snap, 1);
    chk("rst_store_byte0", wmem[12'h50], 8'h0D);

    // Illegal size 11 acts as a word load; also shows the FSM restarted from IDLE.
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h100; lsb_size = 2'b11;
    tick();
    chk("size11_e0", {mem_wr, mem_a}, {1'b0, 32'h100});
    for (int k = 1; k <= 4; k++) tick();
    chk("size11_not_yet", lsb_done, 0);
    tick();
    chk("size11_result", {lsb_done, lsb_rdata}, {1'b1, 32'h44332211});
    lsb_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
